// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: arbiter state enum, default parameter values, clog2 helper.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  // Ceiling log2, never below 1 so a one-bit index is always available.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set request at or after rr_ptr_i, wrapping.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; it only selects, the caller decides whether to accept.
//
// Ports:
//   req_i     in  NUM_REQ   request vector
//   rr_ptr_i  in  ID_WIDTH  highest-priority index (must be < NUM_REQ)
//   found_o   out 1         at least one request set
//   index_o   out ID_WIDTH  winning index (0 when found_o=0)
module rr_priority_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] index_o
);

  int idx;

  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Modulo by subtraction: rr_ptr_i < NUM_REQ so one wrap is enough,
      // and indices >= NUM_REQ are never produced.
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        index_o = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Latency: 0 cycles; a granted word is presented to the FIFO in the same cycle it is offered.
// Backpressure: all req_ready low while fifo_full=1; a locked packet blocks all other requesters.
//
// Ports:
//   wclk, wrst_n      clock / async active-low reset
//   req_valid/data/last, req_ready   per-requester valid/ready word channel
//   fifo_w_en, fifo_data_in, fifo_full   FIFO write port
//   grant_id, locked  current/last owner and packet-in-progress flag
//   word_cnt, stall_cnt  saturating accepted-word and full-stall counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = clog2(NUM_REQ),
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          locked,
  output logic [CNT_WIDTH-1:0]          word_cnt,
  output logic [CNT_WIDTH-1:0]          stall_cnt
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [NUM_REQ-1:0]  elig_oh;   // requester allowed to transfer this cycle
  logic [NUM_REQ-1:0]  sel_oh;    // eligible and actually valid
  logic                sel_last;
  logic                stall;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == id) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [ID_WIDTH-1:0] inc_wrap(input logic [ID_WIDTH-1:0] id);
    return (id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + ID_WIDTH'(1);
  endfunction

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .index_o  (pick_idx)
  );

  // Eligibility and the data mux ignore fifo_full: the owner keeps its ready
  // slot while locked even if it has temporarily dropped valid.
  always_comb begin
    elig_oh = '0;
    if (state_q == ARB_LOCKED) begin
      elig_oh = to_onehot(owner_q);
    end else if (pick_found) begin
      elig_oh = to_onehot(pick_idx);
    end
  end

  assign sel_oh    = elig_oh & req_valid;
  assign req_ready = (wrst_n && !fifo_full) ? elig_oh : '0;
  assign fifo_w_en = |(req_valid & req_ready);
  assign stall     = fifo_full && (|sel_oh);

  always_comb begin
    fifo_data_in = '0;
    sel_last     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i]) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last     = req_last[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_id_d  = grant_id_q;
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (fifo_w_en) begin
      case (state_q)
        ARB_IDLE: begin
          grant_id_d = pick_idx;
          if (sel_last) begin
            // Single-word packet: never locks, pointer moves past the winner.
            rr_ptr_d = inc_wrap(pick_idx);
          end else begin
            state_d = ARB_LOCKED;
            owner_d = pick_idx;
          end
        end
        ARB_LOCKED: begin
          if (sel_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = inc_wrap(owner_q);
          end
        end
        default: state_d = ARB_IDLE;
      endcase
      if (word_cnt_q != '1) begin
        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      end
    end

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_id_q  <= '0;
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_id_q  <= grant_id_d;
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign locked    = (state_q == ARB_LOCKED);
  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter against a depth-8 behavioural write FIFO.
// Latency: n/a (testbench).
// Backpressure: FIFO model raises full at 8 entries; reads are bench-driven.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full = 1'b0;
  logic [1:0]  grant_id;
  logic        locked;
  logic [15:0] word_cnt;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad = 0;
  int wr_viol = 0;
  int inv_viol = 0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_dat = '0;
  logic [7:0] fifo_q[$];

  always #10 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2), .CNT_WIDTH(16)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
    .grant_id(grant_id), .locked(locked),
    .word_cnt(word_cnt), .stall_cnt(stall_cnt)
  );

  // Behavioural FIFO, depth 8: full is the registered pre-edge value.
  always @(posedge wclk) begin
    if (fifo_w_en) begin
      if (fifo_full) wr_viol++;
      else fifo_q.push_back(fifo_data_in);
    end
    if (rd_en && fifo_q.size() > 0) rd_dat = fifo_q.pop_front();
    fifo_full <= (fifo_q.size() == 8);
  end

  // Ready must be one-hot-or-zero and fully suppressed while full.
  always @(negedge wclk) begin
    if ($countones(req_ready) > 1) inv_viol++;
    if (fifo_full && (req_ready != 4'b0000)) inv_viol++;
  end

  task automatic read_word(output logic [7:0] d);
    rd_en = 1'b1;
    @(posedge wclk); #1;
    rd_en = 1'b0;
    d = rd_dat;
  endtask

  task automatic test_reset;
    #1 wrst_n = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h40302010;
    for (int c = 0; c < 3; c++) begin
      @(posedge wclk); #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
      total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", fifo_w_en); end
      total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL rst_word_cnt got=%0d exp=0", word_cnt); end
      total++; if (grant_id !== 2'd0 || locked !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0d/%b exp=0/0", grant_id, locked); end
    end
    wrst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    @(posedge wclk); #1;
  endtask

  task automatic test_round_robin;
    logic [7:0] d;
    logic [7:0] exp_d;
    req_data = 32'h40302010; req_last = 4'b1111; req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_d = 8'(8'h10 * (k % 4 + 1));
      total++; if (req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      total++; if (fifo_data_in !== exp_d) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, fifo_data_in, exp_d); end
      @(posedge wclk); #1;
      total++; if (grant_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant_id, k % 4); end
    end
    req_valid = 4'b0000;
    total++; if (word_cnt !== 16'd8) begin bad++; $display("FAIL rr_word_cnt got=%0d exp=8", word_cnt); end
    for (int k = 0; k < 8; k++) begin
      read_word(d);
      exp_d = 8'(8'h10 * (k % 4 + 1));
      total++; if (d !== exp_d) begin bad++; $display("FAIL rr_fifo_order k=%0d got=%h exp=%h", k, d, exp_d); end
    end
  endtask

  task automatic test_owner_gap;
    logic [7:0] d;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h33;
    req_data = 32'h33000001; req_last = 4'b1000; req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL gap_first got=%b exp=0001", req_ready); end
    @(posedge wclk); #1;
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (req_ready !== 4'b0001 || fifo_w_en !== 1'b0 || locked !== 1'b1) begin
        bad++; $display("FAIL gap_hold c=%0d got=%b/%b/%b exp=0001/0/1", c, req_ready, fifo_w_en, locked);
      end
      @(posedge wclk); #1;
    end
    req_data[7:0] = 8'h02; req_last = 4'b1001; req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001 || fifo_data_in !== 8'h02) begin bad++; $display("FAIL gap_second got=%b/%h exp=0001/02", req_ready, fifo_data_in); end
    @(posedge wclk); #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL gap_unlock got=%b exp=0", locked); end
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL gap_req3 got=%b exp=1000", req_ready); end
    @(posedge wclk); #1;
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL gap_grant got=%0d exp=3", grant_id); end
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      read_word(d);
      total++; if (d !== exp_d[k]) begin bad++; $display("FAIL gap_fifo_order k=%0d got=%h exp=%h", k, d, exp_d[k]); end
    end
  endtask

  task automatic test_packet_lock;
    logic [7:0] d;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hB1;
    req_data = 32'h00B1A100; req_last = 4'b0100; req_valid = 4'b0110;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_first got=%b exp=0010", req_ready); end
    @(posedge wclk); #1;
    total++; if (locked !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL lock_enter got=%b/%0d exp=1/1", locked, grant_id); end
    for (int w = 2; w <= 3; w++) begin
      req_data[15:8] = (w == 2) ? 8'hA2 : 8'hA3;
      req_last[1] = (w == 3);
      #1;
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_block w=%0d got=%b exp=0010", w, req_ready); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_flag w=%0d got=%b exp=1", w, locked); end
      @(posedge wclk); #1;
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_exit got=%b exp=0", locked); end
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL lock_next got=%b exp=0100", req_ready); end
    @(posedge wclk); #1;
    req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      read_word(d);
      total++; if (d !== exp_d[k]) begin bad++; $display("FAIL lock_fifo_order k=%0d got=%h exp=%h", k, d, exp_d[k]); end
    end
  endtask

  task automatic test_full;
    logic [7:0] d;
    logic [7:0] n0, n1;
    logic [3:0] hs;
    logic [7:0] exp_d [8];
    exp_d[0] = 8'hD0; exp_d[1] = 8'hC1; exp_d[2] = 8'hD1; exp_d[3] = 8'hC2;
    exp_d[4] = 8'hD2; exp_d[5] = 8'hC3; exp_d[6] = 8'hD3; exp_d[7] = 8'hC4;
    n0 = 8'd0; n1 = 8'd0;
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL full_stall_start got=%0d exp=0", stall_cnt); end
    req_last = 4'b1111; req_valid = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      req_data[7:0] = 8'hC0 + n0; req_data[15:8] = 8'hD0 + n1;
      #1;
      total++; if (fifo_w_en !== 1'b1) begin bad++; $display("FAIL full_fill c=%0d got=%b exp=1", c, fifo_w_en); end
      hs = req_ready & req_valid;
      @(posedge wclk); #1;
      if (hs[0]) n0 = n0 + 8'd1;
      if (hs[1]) n1 = n1 + 8'd1;
    end
    total++; if (n0 !== 8'd4 || n1 !== 8'd4 || fifo_full !== 1'b1) begin bad++; $display("FAIL full_split got=%0d/%0d/%b exp=4/4/1", n0, n1, fifo_full); end
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (fifo_w_en !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL full_block c=%0d got=%b/%b exp=0/0000", c, fifo_w_en, req_ready); end
      @(posedge wclk); #1;
    end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL full_stall3 got=%0d exp=3", stall_cnt); end
    read_word(d);
    total++; if (d !== 8'hC0) begin bad++; $display("FAIL full_read0 got=%h exp=c0", d); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL full_stall4 got=%0d exp=4", stall_cnt); end
    #1;
    total++; if (fifo_w_en !== 1'b1 || req_ready !== 4'b0001 || fifo_data_in !== 8'hC4) begin
      bad++; $display("FAIL full_release got=%b/%b/%h exp=1/0001/c4", fifo_w_en, req_ready, fifo_data_in);
    end
    @(posedge wclk); #1;
    req_data[7:0] = 8'hC5;
    #1;
    total++; if (fifo_w_en !== 1'b0 || fifo_full !== 1'b1) begin bad++; $display("FAIL full_one_only got=%b/%b exp=0/1", fifo_w_en, fifo_full); end
    @(posedge wclk); #1;
    req_valid = 4'b0000;
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL full_stall5 got=%0d exp=5", stall_cnt); end
    total++; if (word_cnt !== 16'd24) begin bad++; $display("FAIL full_word_cnt got=%0d exp=24", word_cnt); end
    for (int k = 0; k < 8; k++) begin
      read_word(d);
      total++; if (d !== exp_d[k]) begin bad++; $display("FAIL full_fifo_order k=%0d got=%h exp=%h", k, d, exp_d[k]); end
    end
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0] d;
    req_data = 32'h00E000F0; req_last = 4'b0000; req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_first got=%b exp=0100", req_ready); end
    @(posedge wclk); #1;
    total++; if (locked !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL mid_lock got=%b/%0d exp=1/2", locked, grant_id); end
    req_data[23:16] = 8'hE1;
    wrst_n = 1'b0;
    #1;
    total++; if (locked !== 1'b0 || word_cnt !== 16'd0 || stall_cnt !== 16'd0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL mid_rst_state got=%b/%0d/%0d/%0d exp=0/0/0/0", locked, word_cnt, stall_cnt, grant_id);
    end
    total++; if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0) begin bad++; $display("FAIL mid_rst_outs got=%b/%b exp=0000/0", req_ready, fifo_w_en); end
    @(posedge wclk); #1;
    req_valid = 4'b0101; req_last = 4'b0001;
    wrst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_restart got=%b exp=0001", req_ready); end
    @(posedge wclk); #1;
    req_valid = 4'b0000;
    total++; if (word_cnt !== 16'd1 || grant_id !== 2'd0 || locked !== 1'b0) begin
      bad++; $display("FAIL mid_after got=%0d/%0d/%b exp=1/0/0", word_cnt, grant_id, locked);
    end
    read_word(d);
    total++; if (d !== 8'hE0) begin bad++; $display("FAIL mid_partial got=%h exp=e0", d); end
    read_word(d);
    total++; if (d !== 8'hF0) begin bad++; $display("FAIL mid_next got=%h exp=f0", d); end
  endtask

  task automatic test_invariants;
    total++; if (wr_viol !== 0) begin bad++; $display("FAIL write_while_full got=%0d exp=0", wr_viol); end
    total++; if (inv_viol !== 0) begin bad++; $display("FAIL ready_rules got=%0d exp=0", inv_viol); end
    total++; if (fifo_q.size() !== 0) begin bad++; $display("FAIL fifo_leftover got=%0d exp=0", fifo_q.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_owner_gap();
    test_packet_lock();
    test_full();
    test_reset_mid_packet();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter sharing the single write port of asynchronous_fifo between NUM_REQ requesters in the wclk domain.
- Each requester offers words on a valid/ready handshake with a last flag.
- The arbiter grants round-robin at packet granularity, so a packet is never interleaved.
- It drives the FIFO's w_en/data_in and honours the FIFO's full flag, so no write is ever attempted while full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, word width; matches the FIFO's DATA_WIDTH
- ID_WIDTH, 2, width of grant_id; equals clog2(NUM_REQ)
- CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
- wclk  in  1  write-domain clock; all logic is on posedge
- wrst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  final word of the packet
- req_ready  out  NUM_REQ  word accepted this cycle (valid&ready = transfer)
- fifo_w_en  out  1  to FIFO w_en
- fifo_data_in  out  DATA_WIDTH  to FIFO data_in
- fifo_full  in  1  from FIFO full (wclk domain)
- grant_id  out  ID_WIDTH  current/last owner index
- locked  out  1  a packet is in progress
- word_cnt  out  CNT_WIDTH  accepted words, saturating
- stall_cnt  out  CNT_WIDTH  cycles where a request was pending but fifo_full=1, saturating

Behaviour:
- Reset (wrst_n=0, asynchronous): state=IDLE, rr_ptr=0, owner=0, grant_id=0, locked=0, word_cnt=0, stall_cnt=0.
- While wrst_n=0, req_ready and fifo_w_en are forced to 0 combinationally.
- Transfer rule: a word transfers in the cycle where fifo_w_en=1. The FIFO writes at that posedge. Latency from request to write is 0 cycles.
- fifo_w_en = OR(req_valid & req_ready). fifo_data_in = the selected requester's req_data slice. fifo_data_in is 0 when no requester is selected.
- At most one bit of req_ready is high in any cycle. Every req_ready bit is 0 whenever fifo_full=1.
- IDLE state:
  - The winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - If there is a winner and fifo_full=0, then req_ready[winner]=1 and the word transfers.
  - If req_last=1 on that word: stay in IDLE, rr_ptr<=winner+1 (wrapping), grant_id<=winner.
  - If req_last=0 on that word: go to LOCKED, owner<=winner, grant_id<=winner.
  - If fifo_full=1: nothing transfers, the state is unchanged, and there is no lock (nothing was committed).
- LOCKED state:
  - Only the owner is eligible. req_ready[owner] = ~fifo_full. All other bits are 0, even if those requesters are valid.
  - If the owner deasserts valid, the arbiter waits in LOCKED indefinitely (no timeout).
  - A transferred word with req_last=1 returns the state to IDLE with rr_ptr<=owner+1.
  - locked=1 exactly in LOCKED.
- rr_ptr wraps from NUM_REQ-1 to 0. When NUM_REQ is not a power of two, indices >= NUM_REQ are never selected.
- word_cnt increments on each transfer and saturates at all-ones.
- stall_cnt increments when fifo_full=1 and the eligible set has at least one valid request. The eligible set is any requester in IDLE, or the owner in LOCKED. stall_cnt saturates.
- Simultaneous events:
  - A single-word packet (last=1 on the first word) never enters LOCKED.
  - fifo_full rising in the same cycle as a transfer does not cancel that transfer, because the full flag sampled is the pre-edge value.
- Reset mid-packet abandons the lock. The FIFO retains the partial packet. After reset, arbitration restarts at requester 0.
- Requester inputs must hold data/last stable while valid=1 and ready=0. The arbiter does not register the requester inputs.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {ARB_IDLE, ARB_LOCKED}
  - default NUM_REQ/DATA_WIDTH/CNT_WIDTH constants
  - function clog2 for ID_WIDTH
- One sub-module, rr_priority_pick: combinational rotating-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.
- All state, counters and muxing stay in fifo_wr_arbiter.

Test Plan:
All scenarios connect the bench to asynchronous_fifo with DEPTH=8, DATA_WIDTH=8, wclk 50 MHz, rclk 20 MHz.
- Reset: hold wrst_n=0 with all req_valid=1 -> req_ready=0, fifo_w_en=0, word_cnt=0, grant_id=0 throughout; after release the first grant goes to requester 0.
- Round-robin: requesters 0..3 each send a single-word packet (0x10,0x20,0x30,0x40, last=1) continuously valid -> FIFO receives 10,20,30,40,10,... with grant_id cycling 0,1,2,3.
- Packet lock: requester 1 sends 3-word packet A1,A2,A3 while requester 2 is valid with B1 -> read order A1,A2,A3,B1; locked=1 for the two cycles after A1; req_ready[2]=0 until A3 transfers.
- Owner gap: requester 0 sends 0x01 (last=0), drops valid for 5 cycles, then sends 0x02 (last=1); requester 3 is valid throughout -> requester 3 is not served until after 0x02; FIFO order 01,02,then requester 3's word.
- Full backpressure: no reads, requesters 0 and 1 stream 12 words -> exactly 8 transfers, fifo_w_en=0 while full, stall_cnt increments each blocked cycle; reading one word releases exactly one further transfer; final read-out matches write order.
- Reset mid-packet: assert wrst_n during the second word of a 4-word packet -> locked=0 and counters=0 immediately; next grant follows rr_ptr=0.
